// File: rtl/bitcell_array.sv
// bitcell_array: DEPTH x WIDTH word store with a per-word written mask,
// one-cycle registered reads, read-of-unwritten error flag and a
// saturating access counter.
//
// Handshake: an access is accepted at every rising edge where valid=1 and
// rst=0. There is no ready; the block never stalls. rw=1 writes wdata to
// mem[addr]. rw=0 reads mem[addr]. The read result appears in rdata with
// rdata_valid (and rd_err if the word was never written) high for exactly
// the following cycle. With valid=0, rw/addr/wdata are ignored.
module bitcell_array #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic                     rw,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rdata_valid,
    output logic                     rd_err,
    output logic [7:0]               acc_cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written;

    logic wr_acc;
    logic rd_acc;

    // Reset has priority: nothing is accepted at a reset edge.
    always_comb begin
        wr_acc = valid && rw && !rst;
        rd_acc = valid && !rw && !rst;
    end

    // Word storage; contents survive reset, only the written mask is cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[addr] <= wdata;
        end
    end

    // Written mask: set on write, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            written <= '0;
        end else if (wr_acc) begin
            written[addr] <= 1'b1;
        end
    end

    // Read response: rdata holds between reads; valid/err pulse one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rd_err      <= 1'b0;
        end else begin
            rdata_valid <= rd_acc;
            rd_err      <= rd_acc && !written[addr];
            if (rd_acc) begin
                rdata <= mem[addr];
            end
        end
    end

    // Saturating count of accepted accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if ((wr_acc || rd_acc) && (acc_cnt != 8'hFF)) begin
            acc_cnt <= acc_cnt + 8'd1;
        end
    end

endmodule

// File: doc/bitcell_array.md
BITCELL_ARRAY -- requirements
Module: bitcell_array

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, defining the data bits per word.
REQ-002 The module SHALL have parameter DEPTH, default 8, defining the number of words; it is a power of two and at least 2.
REQ-003 The module SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-005 The module SHALL have port valid, input, width 1: the access request strobe from the access FSM.
REQ-006 The module SHALL have port rw, input, width 1: the access type from the access FSM; 1 means write, 0 means read.
REQ-007 The module SHALL have port addr, input, width log2(DEPTH): the word address.
REQ-008 The module SHALL have port wdata, input, width WIDTH: the write data.
REQ-009 The module SHALL have port rdata, output, width WIDTH: the registered read data.
REQ-010 The module SHALL have port rdata_valid, output, width 1: a one-cycle pulse that qualifies rdata.
REQ-011 The module SHALL have port rd_err, output, width 1: a one-cycle pulse, coincident with rdata_valid, flagging a read of a never-written word.
REQ-012 The module SHALL have port acc_cnt, output, width 8: a saturating count of accepted accesses.

Function
REQ-013 The storage SHALL be DEPTH words x WIDTH bits, plus a DEPTH-bit written mask.
REQ-014 A write SHALL occur at an edge where valid=1 and rw=1: mem[addr] takes wdata and written[addr] is set to 1 at that edge.
REQ-015 A read SHALL be accepted at an edge where valid=1 and rw=0, and SHALL produce its result at that same edge.
- rdata takes mem[addr].
- rdata_valid is 1 for exactly the following cycle.
- rd_err is 1 for that same cycle if written[addr]=0.
REQ-016 The read latency SHALL be one cycle, from the request edge to rdata_valid high.
REQ-017 Reads SHALL return the value before any write at the same edge; only one access exists per cycle, so a read and a write never collide.
REQ-018 A read one cycle after a write to the same address SHALL return the newly written data.
REQ-019 rdata SHALL hold its last read value while rdata_valid=0; writes do not change rdata.
REQ-020 With valid=0, rw, addr and wdata SHALL be ignored: no storage change and no pulse.
REQ-021 acc_cnt SHALL increment by 1 on each accepted access, read or write.
REQ-022 acc_cnt SHALL saturate at 255 with no wrap.
REQ-023 Back-to-back accesses on consecutive cycles SHALL all be accepted; the block never stalls and has no backpressure.
REQ-024 rd_err SHALL be 0 whenever rdata_valid=0.
REQ-025 An addr value at or above DEPTH is impossible by width, so no out-of-range handling SHALL be included.

Reset
REQ-026 While rst=1 at an edge, the following outputs SHALL be forced at that edge: rdata=0, rdata_valid=0, rd_err=0, acc_cnt=0.
REQ-027 While rst=1 at an edge, the written mask SHALL be cleared to all zeros at that edge.
REQ-028 Reset SHALL take priority over any access presented at the same edge: no write occurs, no read pulse is produced, and no count is added.
REQ-029 The mem contents SHALL NOT be cleared by reset; they become unreadable without error only because the written mask is cleared.
REQ-030 Reset asserted in the cycle after a read request SHALL suppress that read's rdata_valid pulse; the response is cleared at the reset edge.
REQ-031 The first edge with rst=0 SHALL accept any access presented at that edge.

Verification
REQ-032 Reset, then write 0xA to addr 3, then read addr 3 on the next cycle -> rdata=0xA, rdata_valid=1 for one cycle, rd_err=0, acc_cnt=2.
REQ-033 After reset, read addr 5 -> rdata_valid=1, rd_err=1, rdata equals mem[5] contents (don't-care after power-up).
REQ-034 Write addr 0..7 with data 0x1..0x8, then read 7..0 back-to-back -> eight consecutive rdata_valid cycles with data 0x8..0x1, no rd_err, acc_cnt=16.
REQ-035 Write 0x5 to addr 2, assert rst, write nothing, read addr 2 -> rd_err=1; acc_cnt counts only the post-reset read (1).
REQ-036 Perform 300 accesses with valid held high -> acc_cnt stops at 255; valid=0 cycles leave all outputs unchanged except that rdata_valid falls to 0.
REQ-037 Read request at edge N with rst=1 at edge N+1 -> rdata_valid=0 after edge N+1, rdata=0, acc_cnt=0.
